// File: rtl/apb_requester_engine_if.sv
// Command, response and APB bus bundle for apb_requester_engine.
// master = the engine; slave = command source / response sink / APB completer side.
interface apb_requester_engine_if #(
    parameter int ADDR_WIDTH = 16
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [31:0]           cmd_wdata;
    logic [3:0]            cmd_strb;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [31:0]           rsp_rdata;
    logic                  rsp_err;
    logic                  rsp_timeout;

    logic                  pclk;
    logic                  preset_n;
    logic                  psel;
    logic                  penable;
    logic [ADDR_WIDTH-1:0] paddr;
    logic                  pwrite;
    logic [31:0]           pwdata;
    logic [3:0]            pstrb;
    logic [2:0]            pprot;
    logic                  pready;
    logic [31:0]           prdata;
    logic                  pslverr;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  rsp_ready,
        output pclk, preset_n, psel, penable, paddr, pwrite, pwdata, pstrb, pprot,
        input  pready, prdata, pslverr
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output rsp_ready,
        input  pclk, preset_n, psel, penable, paddr, pwrite, pwdata, pstrb, pprot,
        output pready, prdata, pslverr
    );
endinterface

// File: rtl/apb_requester_engine.sv
// Single-outstanding APB requester: valid/ready command -> APB SETUP/ACCESS -> valid/ready response.
// Latency: IDLE, SETUP, ACCESS (+1 per PREADY wait), RESP; 4 cycles minimum per transfer.
// Backpressure: cmd_ready low from accept until the response is taken; rsp_ready low holds RESP. Watchdog: APB_REQUESTER_TIMEOUT_EN.
module apb_requester_engine #(
    parameter int ADDR_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    apb_requester_engine_if.master bus
);
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_RESP
    } state_e;

    state_e                state_q, state_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic                  pwrite_q, pwrite_d;
    logic [31:0]           pwdata_q, pwdata_d;
    logic [3:0]            pstrb_q, pstrb_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic                  tmo_q, tmo_d;
    logic                  access_timeout;

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("apb_requester_engine: TIMEOUT_CYCLES must be at least 2");
    end

`ifdef APB_REQUESTER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == ST_SETUP) begin
            cnt_d = '0;
        end else if (state_q == ST_ACCESS && !bus.pready) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Fires on the cycle whose un-ready edge would bring the count to the limit; pready wins.
    assign access_timeout = !bus.pready && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign access_timeout = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        paddr_d  = paddr_q;
        pwrite_d = pwrite_q;
        pwdata_d = pwdata_q;
        pstrb_d  = pstrb_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        tmo_d    = tmo_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.cmd_valid && cmd_ready_q) begin
                    paddr_d  = bus.cmd_addr;
                    pwrite_d = bus.cmd_write;
                    pwdata_d = bus.cmd_wdata;
                    pstrb_d  = bus.cmd_write ? bus.cmd_strb : 4'h0;
                    state_d  = ST_SETUP;
                end
            end
            ST_SETUP: begin
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (bus.pready) begin
                    rdata_d = pwrite_q ? 32'h0 : bus.prdata;
                    err_d   = bus.pslverr;
                    tmo_d   = 1'b0;
                    state_d = ST_RESP;
                end else if (access_timeout) begin
                    rdata_d = 32'h0;
                    err_d   = 1'b1;
                    tmo_d   = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Registered ready: high exactly when the next state is IDLE, so it stays low through reset.
        cmd_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cmd_ready_q <= 1'b0;
            paddr_q     <= '0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= 32'h0;
            pstrb_q     <= 4'h0;
            rdata_q     <= 32'h0;
            err_q       <= 1'b0;
            tmo_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            paddr_q     <= paddr_d;
            pwrite_q    <= pwrite_d;
            pwdata_q    <= pwdata_d;
            pstrb_q     <= pstrb_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            tmo_q       <= tmo_d;
        end
    end

    assign bus.cmd_ready   = cmd_ready_q;
    assign bus.rsp_valid   = (state_q == ST_RESP);
    assign bus.rsp_rdata   = rdata_q;
    assign bus.rsp_err     = err_q;
    assign bus.rsp_timeout = tmo_q;

    assign bus.pclk     = clk;
    assign bus.preset_n = !rst;
    assign bus.psel     = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
    assign bus.penable  = (state_q == ST_ACCESS);
    assign bus.paddr    = paddr_q;
    assign bus.pwrite   = pwrite_q;
    assign bus.pwdata   = pwdata_q;
    assign bus.pstrb    = pstrb_q;
    assign bus.pprot    = 3'b000;
endmodule

// File: tb/tb_apb_requester_engine.sv
// Directed bench for apb_requester_engine: scoreboard of expected responses plus cycle-level APB checks.
module tb_apb_requester_engine;
    localparam int AW  = 16;
    localparam int TMO = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    apb_requester_engine_if #(.ADDR_WIDTH(AW)) bus ();

    apb_requester_engine #(
        .ADDR_WIDTH     (AW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic        tmo;
    } rsp_t;

    rsp_t        exp_q[$];
    rsp_t        mon_e;
    int          checks   = 0;
    int          failures = 0;

    int          cpl_wait  = 0;
    logic [31:0] cpl_rdata = 32'h0;
    logic        cpl_err   = 1'b0;
    int          acc_cnt   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic push_exp(input logic [31:0] r, input logic e, input logic t);
        exp_q.push_back({r, e, t});
    endtask

    // Completer: pready on ACCESS cycle number cpl_wait (0-based); -1 never. Drives junk outside ACCESS.
    always @(negedge clk) begin
        if (bus.psel && bus.penable) begin
            bus.pready  = (acc_cnt == cpl_wait);
            bus.pslverr = cpl_err;
            bus.prdata  = cpl_rdata;
            acc_cnt++;
        end else begin
            bus.pready  = 1'b1;
            bus.pslverr = 1'b1;
            bus.prdata  = 32'hBAD0_BAD0;
            acc_cnt     = 0;
        end
    end

    // Monitor: every response handshake is compared against the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && bus.rsp_valid && bus.rsp_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rsp_unexpected actual=rdata 0x%0h err %0b required=no response",
                         bus.rsp_rdata, bus.rsp_err);
            end else begin
                mon_e = exp_q.pop_front();
                check("rsp_rdata", 64'(bus.rsp_rdata), 64'(mon_e.rdata));
                check("rsp_err", 64'(bus.rsp_err), 64'(mon_e.err));
                check("rsp_timeout", 64'(bus.rsp_timeout), 64'(mon_e.tmo));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entered at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send(input logic w, input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = w;
        bus.cmd_addr  = a;
        bus.cmd_wdata = d;
        bus.cmd_strb  = s;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.cmd_ready && n < 200);
        if (!bus.cmd_ready) begin
            checks++;
            failures++;
            $display("FAIL cmd_accept actual=no cmd_ready in %0d cycles required=accept", n);
        end
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(name, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic count_access(input string name, input int req);
        int acc = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!bus.penable) break;
            acc++;
        end
        check(name, 64'(acc), 64'(req));
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout actual=still running required=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        int acc;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = 32'h0;
        bus.cmd_strb  = 4'h0;
        bus.rsp_ready = 1'b1;

        repeat (3) @(negedge clk);
        check("rst_psel", 64'(bus.psel), 64'd0);
        check("rst_penable", 64'(bus.penable), 64'd0);
        check("rst_cmd_ready", 64'(bus.cmd_ready), 64'd0);
        check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("rst_rsp_err", 64'(bus.rsp_err), 64'd0);
        check("rst_rsp_timeout", 64'(bus.rsp_timeout), 64'd0);
        check("rst_paddr", 64'(bus.paddr), 64'd0);
        check("rst_pwdata", 64'(bus.pwdata), 64'd0);
        check("rst_pstrb", 64'(bus.pstrb), 64'd0);
        check("rst_pwrite", 64'(bus.pwrite), 64'd0);
        check("rst_rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
        check("rst_preset_n", 64'(bus.preset_n), 64'd0);

        tick();
        rst = 1'b0;
        @(negedge clk);
        check("cmd_ready_before_edge", 64'(bus.cmd_ready), 64'd0);
        check("preset_n_released", 64'(bus.preset_n), 64'd1);
        @(negedge clk);
        check("cmd_ready_after_edge", 64'(bus.cmd_ready), 64'd1);

        // Zero-wait write: cycle-exact phase sequence, rdata forced 0.
        tick();
        cpl_wait = 0; cpl_err = 1'b0; cpl_rdata = 32'h1111_2222;
        push_exp(32'h0, 1'b0, 1'b0);
        send(1'b1, 16'h0404, 32'hDEAD_BEEF, 4'hF);
        @(negedge clk);
        check("wr_setup_psel", 64'(bus.psel), 64'd1);
        check("wr_setup_penable", 64'(bus.penable), 64'd0);
        check("wr_setup_paddr", 64'(bus.paddr), 64'h0404);
        check("wr_setup_pwrite", 64'(bus.pwrite), 64'd1);
        check("wr_setup_pwdata", 64'(bus.pwdata), 64'hDEAD_BEEF);
        check("wr_setup_pstrb", 64'(bus.pstrb), 64'hF);
        check("wr_setup_pprot", 64'(bus.pprot), 64'd0);
        check("wr_setup_cmd_ready", 64'(bus.cmd_ready), 64'd0);
        @(negedge clk);
        check("wr_access_psel", 64'(bus.psel), 64'd1);
        check("wr_access_penable", 64'(bus.penable), 64'd1);
        @(negedge clk);
        check("wr_resp_valid", 64'(bus.rsp_valid), 64'd1);
        check("wr_resp_psel", 64'(bus.psel), 64'd0);
        @(negedge clk);
        check("wr_idle_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        check("wr_idle_rsp_valid", 64'(bus.rsp_valid), 64'd0);

        // Read with 3 wait states: 4 ACCESS cycles, address stable, strobes zero.
        tick();
        cpl_wait = 3; cpl_err = 1'b0; cpl_rdata = 32'h1234_5678;
        push_exp(32'h1234_5678, 1'b0, 1'b0);
        send(1'b0, 16'h0800, 32'hFFFF_FFFF, 4'hF);
        @(negedge clk);
        check("rd_setup_pstrb", 64'(bus.pstrb), 64'd0);
        check("rd_setup_pwrite", 64'(bus.pwrite), 64'd0);
        acc = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!bus.penable) break;
            acc++;
            check("rd_paddr_stable", 64'(bus.paddr), 64'h0800);
            check("rd_pstrb_zero", 64'(bus.pstrb), 64'd0);
        end
        check("rd_access_cycles", 64'(acc), 64'd4);
        check("rd_rsp_valid", 64'(bus.rsp_valid), 64'd1);
        drain("rd_drain");

        // Read with PSLVERR, then response stalled 10 cycles while the next command waits.
        tick();
        bus.rsp_ready = 1'b0;
        cpl_wait = 0; cpl_err = 1'b1; cpl_rdata = 32'hA5A5_0001;
        push_exp(32'hA5A5_0001, 1'b1, 1'b0);
        send(1'b0, 16'h0810, 32'h0, 4'h0);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b1;
        bus.cmd_addr  = 16'h0C00;
        bus.cmd_wdata = 32'h0BAD_F00D;
        bus.cmd_strb  = 4'h3;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) break;
        end
        check("err_rsp_valid", 64'(bus.rsp_valid), 64'd1);
        for (int i = 0; i < 10; i++) begin
            check("stall_rsp_valid", 64'(bus.rsp_valid), 64'd1);
            check("stall_rsp_rdata", 64'(bus.rsp_rdata), 64'hA5A5_0001);
            check("stall_rsp_err", 64'(bus.rsp_err), 64'd1);
            check("stall_rsp_timeout", 64'(bus.rsp_timeout), 64'd0);
            check("stall_cmd_ready", 64'(bus.cmd_ready), 64'd0);
            check("stall_psel", 64'(bus.psel), 64'd0);
            @(negedge clk);
        end
        tick();
        bus.rsp_ready = 1'b1;
        cpl_wait = 1; cpl_err = 1'b0; cpl_rdata = 32'h7777_7777;
        push_exp(32'h0, 1'b0, 1'b0);
        @(negedge clk);
        check("release_cmd_ready_low", 64'(bus.cmd_ready), 64'd0);
        @(negedge clk);
        check("release_cmd_ready_high", 64'(bus.cmd_ready), 64'd1);
        tick();
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        check("wr2_setup_pwdata", 64'(bus.pwdata), 64'h0BAD_F00D);
        check("wr2_setup_pstrb", 64'(bus.pstrb), 64'h3);
        drain("wr2_drain");

        // Write completed with PSLVERR: err set, rdata still 0.
        tick();
        cpl_wait = 0; cpl_err = 1'b1; cpl_rdata = 32'hFEED_FACE;
        push_exp(32'h0, 1'b1, 1'b0);
        send(1'b1, 16'h0104, 32'h55AA_55AA, 4'h1);
        drain("wrerr_drain");

`ifdef APB_REQUESTER_TIMEOUT_EN
        // Completer never ready: abort after TMO ACCESS cycles.
        tick();
        cpl_wait = -1; cpl_err = 1'b0; cpl_rdata = 32'hCAFE_0000;
        push_exp(32'h0, 1'b1, 1'b1);
        send(1'b0, 16'h0900, 32'h0, 4'h0);
        @(negedge clk);
        count_access("tmo_access_cycles", TMO);
        check("tmo_psel_dropped", 64'(bus.psel), 64'd0);
        check("tmo_rsp_valid", 64'(bus.rsp_valid), 64'd1);
        drain("tmo_drain");

        // pready on the last permitted cycle wins over the watchdog.
        tick();
        cpl_wait = TMO - 1; cpl_err = 1'b0; cpl_rdata = 32'h600D_600D;
        push_exp(32'h600D_600D, 1'b0, 1'b0);
        send(1'b0, 16'h0904, 32'h0, 4'h0);
        @(negedge clk);
        count_access("tmo_edge_access_cycles", TMO);
        drain("tmo_edge_drain");
`endif

        // Reset mid-ACCESS: APB drops without a clock edge, transfer discarded.
        tick();
        cpl_wait = -1; cpl_err = 1'b0; cpl_rdata = 32'h0;
        send(1'b0, 16'h0A00, 32'h0, 4'h0);
        @(negedge clk);
        @(negedge clk);
        check("rstmid_pre_penable", 64'(bus.penable), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("rstmid_psel", 64'(bus.psel), 64'd0);
        check("rstmid_penable", 64'(bus.penable), 64'd0);
        check("rstmid_cmd_ready", 64'(bus.cmd_ready), 64'd0);
        check("rstmid_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        repeat (2) @(negedge clk);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rstrel_cmd_ready_before", 64'(bus.cmd_ready), 64'd0);
        check("rstrel_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        @(negedge clk);
        check("rstrel_cmd_ready_after", 64'(bus.cmd_ready), 64'd1);
        check("rstrel_psel", 64'(bus.psel), 64'd0);
        check("rstrel_rsp_valid2", 64'(bus.rsp_valid), 64'd0);

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/apb_requester_engine.md
# apb_requester_engine

Single-outstanding APB requester that turns a simple valid/ready command stream into APB SETUP/ACCESS transfers and returns read data and error status on a valid/ready response stream. It sits upstream of an APB bridge or register slice, letting a non-CPU master such as a DMA sequencer or test harness drive the existing APB completer peripherals. An optional watchdog aborts transfers to a completer that never asserts PREADY.

## Interface
- ADDR_WIDTH, 16, width of `cmd_addr` and `apb.paddr`; must match the attached APB interface.
- TIMEOUT_CYCLES, 1024, number of ACCESS-phase cycles without PREADY before abort. Used only with the watchdog compiled in. Must be at least 2.
- clk  in  1  clock; also drives `apb.pclk`.
- rst  in  1  reset, asynchronous, active-high; `apb.preset_n` is driven as `!rst`.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when both `cmd_valid` and `cmd_ready` are high at the clock edge.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  byte address.
- cmd_wdata  in  32  write data.
- cmd_strb  in  4  write byte strobes.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  32  read data; 0 for writes and for timeouts.
- rsp_err  out  1  PSLVERR captured, or timeout.
- rsp_timeout  out  1  transfer aborted by the watchdog.
- apb  APB.requester  DATA_WIDTH 32, USER_WIDTH 0  drives psel, penable, paddr, pwrite, pwdata, pstrb, pprot (tied 0); samples pready, prdata, pslverr.

## Operation
- The FSM has four states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - `cmd_ready` = 1.
  - On handshake, register addr, write, wdata and strb. `pstrb` is forced to 0 for reads.
  - Go to SETUP.
- SETUP:
  - psel = 1, penable = 0.
  - Unconditionally go to ACCESS.
- ACCESS:
  - psel = 1, penable = 1.
  - When `pready` = 1: capture `prdata` (reads only, else 0) and `pslverr`, drop psel/penable on the next edge, and go to RESP.
- RESP:
  - `rsp_valid` = 1. Outputs are held stable until `rsp_ready` = 1.
  - On the handshake edge, go to IDLE.
- Exactly one transfer is outstanding. A new command is never accepted while in SETUP, ACCESS or RESP.
- paddr, pwrite, pwdata and pstrb stay stable from SETUP through the end of ACCESS, and hold their last values while in IDLE.
- `rsp_err` = `pslverr` sampled with `pready`. A write with `pslverr` returns rdata 0 and err 1.

## Timing
- Reset values, and values while `rst` is high:
  - psel, penable, cmd_ready, rsp_valid, rsp_err and rsp_timeout are 0.
  - paddr, pwdata, pstrb, pwrite and rsp_rdata are 0.
  - State is IDLE.
- `cmd_ready` is registered. It rises on the first clock edge after `rst` deasserts.
- Reset asserted mid-transfer drops psel/penable immediately (asynchronously). The in-flight command and any pending response are discarded.
- Minimum latency, with the command accepted at edge N:
  - N+1: SETUP.
  - N+2: ACCESS; `pready` = 1 is sampled here.
  - N+3: `rsp_valid` = 1.
  - If `rsp_ready` is already high, IDLE and `cmd_ready` = 1 at N+4.
- Peak throughput is one transfer per 4 cycles. Each PREADY wait state adds 1 cycle.
- `rsp_ready` held low stalls the engine in RESP indefinitely. `cmd_ready` stays 0 meanwhile.
- `pready` / `pslverr` are ignored outside ACCESS.

## Configuration
- `APB_REQUESTER_TIMEOUT_EN` defined:
  - A counter clears on entry to ACCESS and increments each ACCESS cycle with `pready` = 0.
  - When it reaches TIMEOUT_CYCLES: psel/penable drop, and the FSM enters RESP with rsp_timeout = 1, rsp_err = 1, rsp_rdata = 0.
  - If `pready` arrives in the same cycle the count hits the limit, `pready` wins and this is a normal completion.
  - The counter width is $clog2(TIMEOUT_CYCLES+1).
- Not defined:
  - No counter is built; ACCESS waits forever.
  - `rsp_timeout` is tied 0.

## Test plan
- Write addr 0x0404, wdata 0xDEADBEEF, strb 0xF, zero-wait completer -> SETUP at N+1 with psel=1/penable=0, ACCESS at N+2, rsp_valid at N+3 with err=0, rdata=0.
- Read addr 0x0800 with 3 wait states, completer returns 0x12345678 -> ACCESS lasts 4 cycles, paddr stable throughout, rsp_rdata=0x12345678, pstrb=0 during the transfer.
- Read with pslverr=1 alongside pready -> rsp_err=1, rsp_timeout=0; next command accepted only after rsp_ready.
- rsp_ready held low 10 cycles with cmd_valid high -> rsp_valid and data stable, cmd_ready=0, psel=0 for all 10 cycles.
- Macro on, TIMEOUT_CYCLES=8, pready never asserts -> psel drops after 8 ACCESS cycles, rsp_timeout=1, rsp_err=1, rdata=0. Repeat with pready at cycle 8 -> normal completion.
- rst pulsed during ACCESS -> psel/penable go low without waiting for clk, no rsp_valid, cmd_ready=1 one edge after release.
